mult_sequencer: RTL and testbench
=================================

Name: mult_sequencer

Overview:
Control FSM for the 32-bit multiplier datapath. Collects operands A and B one byte at a time from the 8-bit switch input, paced by the enter button. Drives the multiplier operands, waits a fixed settle latency, and captures the 32-bit product. Pages the product onto the 16-bit (4-digit hex) display. Sits between the board inputs and the multiplier/peripherals pair at datapath top level.

Parameters:
LATENCY, 2, cycles from operands stable to product capture (legal range 1..15)
BYTES, 4, bytes per operand (fixed at 4 for 32-bit operands)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
enter  input  1  raw push-button level, active-high, asynchronous to clk
inputdata  input  8  switch byte
dataR  input  32  product from multiplier (combinational from dataA/dataB)
dataA  output  32  operand A register to multiplier
dataB  output  32  operand B register to multiplier
result  output  32  captured product
inputdata_ready  output  1  high while a byte is expected (LOAD_A, LOAD_B)
loaddata  output  1  one-cycle pulse on each accepted byte
result_valid  output  1  high while result holds a product of current operands
disp_page  output  1  0 = result[15:0] shown, 1 = result[31:16] shown
byte_cnt  output  2  bytes accepted in current operand
state  output  2  IDLE=0, LOAD_A=1, LOAD_B=2 (WAIT and SHOW share a separate encoding, see below)

Behaviour:
- Reset (reset=0, async): state=IDLE. byte_cnt=0. dataA, dataB, result=0. inputdata_ready, loaddata, result_valid, disp_page=0. Sync flops and latency counter cleared.
- Reset mid-operation: everything above cleared immediately. Partial operands are discarded.
- Enter conditioning: enter passes through 2 sync flops (s1, s2) plus a history flop s3. press = s2 & ~s3.
  - A byte is captured on the 3rd rising edge after enter rises.
  - Holding enter gives exactly one press. A new press needs enter low for at least 2 cycles.
- Internal FSM has 5 states: IDLE, LOAD_A, LOAD_B, WAIT, SHOW.
  - state output encoding: IDLE=0, LOAD_A=1, LOAD_B=2, WAIT=3, SHOW=3. The bench distinguishes WAIT from SHOW with result_valid.
- IDLE -> LOAD_A on the first clock after reset is released. No press is needed.
- LOAD_A, on press:
  - dataA <= {dataA[23:0], inputdata}, so the first byte ends up most significant.
  - loaddata pulses for 1 cycle. byte_cnt increments.
  - On the 4th byte: byte_cnt wraps to 0 and state -> LOAD_B.
- Entering LOAD_A from SHOW: dataA and dataB are cleared and result_valid goes low on the transition edge.
- LOAD_B: same as LOAD_A but fills dataB. On the 4th byte: state -> WAIT and the latency counter loads LATENCY-1.
- WAIT:
  - inputdata_ready=0. Presses are ignored and discarded, not queued.
  - Counter decrements each cycle. In the cycle where it reads 0: result <= dataR, result_valid <= 1, disp_page <= 0, state -> SHOW.
  - Total: result valid LATENCY cycles after the edge that accepted the last B byte.
- SHOW:
  - 1st press: disp_page 0 -> 1.
  - 2nd press: state -> LOAD_A (new operation; disp_page stays 1 until the next product capture).
  - result is held stable in SHOW.
- Arithmetic: product is dataR as supplied, truncated 32-bit. No overflow flag.
- Simultaneous events: press coinciding with the final WAIT cycle is discarded. Reset dominates everything.
- loaddata never asserts outside LOAD_A/LOAD_B. inputdata_ready is a registered function of state.

Test Plan:
- Release reset with enter=0 -> all outputs 0. Next cycle state=1, inputdata_ready=1.
- Press with inputdata=0x12, 0x34, 0x56, 0x78 -> dataA=0x12345678, 4 loaddata pulses, byte_cnt 1,2,3,0, state=2.
- Load B bytes 0x00,0x00,0x00,0x03 with A=0x00000005 (dataR driven as A*B) -> result=0x0000000F and result_valid=1 exactly 2 cycles after the last B capture, disp_page=0.
- In SHOW with result=0xDEADBEEF: press -> disp_page=1. Press again -> state=1, result_valid=0, dataA=dataB=0.
- Hold enter high for 20 cycles in LOAD_A -> exactly one byte accepted. Pulse enter during WAIT -> no loaddata, no state change.
- Assert reset=0 after 2 bytes of B are loaded -> immediate clear of all outputs. After release, a full A/B sequence (0xFFFFFFFF x 0x00000002) gives result=0xFFFFFFFE.

Source files
------------

// File: rtl/mult_sequencer_if.sv
// mult_sequencer_if: board/multiplier-side signals of the multiplier control sequencer.
interface mult_sequencer_if;
   logic        enter;
   logic [7:0]  inputdata;
   logic [31:0] dataR;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic [31:0] result;
   logic        inputdata_ready;
   logic        loaddata;
   logic        result_valid;
   logic        disp_page;
   logic [1:0]  byte_cnt;
   logic [1:0]  state;
   modport master (
      output enter, inputdata, dataR,
      input  dataA, dataB, result, inputdata_ready, loaddata, result_valid, disp_page, byte_cnt, state
   );
   modport slave (
      input  enter, inputdata, dataR,
      output dataA, dataB, result, inputdata_ready, loaddata, result_valid, disp_page, byte_cnt, state
   );
endinterface

// File: rtl/mult_sequencer.sv
// mult_sequencer: collects two 32-bit operands bytewise, waits for the multiplier, captures and pages the product.
module mult_sequencer #(
   parameter int LATENCY = 2,
   parameter int BYTES   = 4
) (
   input logic              clk,
   input logic              reset,
   mult_sequencer_if.slave  bus
);
   // WAIT and SHOW share the low two bits so the visible state code is just r_state[1:0]
   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      LOAD_A = 3'b001,
      LOAD_B = 3'b010,
      WAIT   = 3'b011,
      SHOW   = 3'b111
   } state_t;
   state_t      r_state;
   logic        r_s1, r_s2, r_s3;
   logic [3:0]  r_cnt;
   logic [1:0]  r_byte_cnt;
   logic [31:0] r_data_a, r_data_b, r_result;
   logic        r_ready, r_load, r_valid, r_page;
   logic        w_press, w_last;
   assign w_press = r_s2 & ~r_s3;
   assign w_last  = r_byte_cnt == 2'(BYTES - 1);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_s1       <= 1'b0;
         r_s2       <= 1'b0;
         r_s3       <= 1'b0;
         r_cnt      <= '0;
         r_byte_cnt <= '0;
         r_data_a   <= '0;
         r_data_b   <= '0;
         r_result   <= '0;
         r_ready    <= 1'b0;
         r_load     <= 1'b0;
         r_valid    <= 1'b0;
         r_page     <= 1'b0;
      end else begin
         r_s1   <= bus.enter;
         r_s2   <= r_s1;
         r_s3   <= r_s2;
         r_load <= 1'b0;
         case (r_state)
            IDLE: begin
               r_state <= LOAD_A;
               r_ready <= 1'b1;
            end
            LOAD_A: if (w_press) begin
               r_data_a   <= {r_data_a[23:0], bus.inputdata};
               r_load     <= 1'b1;
               r_byte_cnt <= w_last ? 2'd0 : r_byte_cnt + 2'd1;
               if (w_last) r_state <= LOAD_B;
            end
            LOAD_B: if (w_press) begin
               r_data_b   <= {r_data_b[23:0], bus.inputdata};
               r_load     <= 1'b1;
               r_byte_cnt <= w_last ? 2'd0 : r_byte_cnt + 2'd1;
               if (w_last) begin
                  r_state <= WAIT;
                  r_ready <= 1'b0;
                  r_cnt   <= 4'(LATENCY - 1);
               end
            end
            WAIT: if (r_cnt == 4'd0) begin
               r_result <= bus.dataR;
               r_valid  <= 1'b1;
               r_page   <= 1'b0;
               r_state  <= SHOW;
            end else begin
               r_cnt <= r_cnt - 4'd1;
            end
            SHOW: if (w_press) begin
               // first press flips to the upper half, the next one starts a new operation
               if (!r_page) begin
                  r_page <= 1'b1;
               end else begin
                  r_state  <= LOAD_A;
                  r_data_a <= '0;
                  r_data_b <= '0;
                  r_valid  <= 1'b0;
                  r_ready  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign bus.dataA           = r_data_a;
   assign bus.dataB           = r_data_b;
   assign bus.result          = r_result;
   assign bus.inputdata_ready = r_ready;
   assign bus.loaddata        = r_load;
   assign bus.result_valid    = r_valid;
   assign bus.disp_page       = r_page;
   assign bus.byte_cnt        = r_byte_cnt;
   assign bus.state           = r_state[1:0];
endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: directed-vector bench for the multiplier control sequencer.
module tb_mult_sequencer;
   logic clk;
   logic reset;
   logic use_prod;
   int   n_chk;
   int   n_err;
   int   n_ld;
   int   ld0;
   mult_sequencer_if mif ();
   mult_sequencer #(.LATENCY(2), .BYTES(4)) dut (.clk(clk), .reset(reset), .bus(mif));
   assign mif.dataR = use_prod ? mif.dataA * mif.dataB : 32'hDEADBEEF;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(negedge clk) if (mif.loaddata === 1'b1) n_ld++;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask
   task automatic press(input logic [7:0] b, input logic exp_ld);
      mif.inputdata = b;
      mif.enter = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("press_ld", 32'(mif.loaddata), 32'(exp_ld));
      mif.enter = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask
   task automatic chk_cleared(input string tag);
      chk({tag, "_state"}, 32'(mif.state), 0);
      chk({tag, "_bcnt"}, 32'(mif.byte_cnt), 0);
      chk({tag, "_a"}, mif.dataA, 0);
      chk({tag, "_b"}, mif.dataB, 0);
      chk({tag, "_res"}, mif.result, 0);
      chk({tag, "_flags"}, 32'({mif.inputdata_ready, mif.loaddata, mif.result_valid, mif.disp_page}), 0);
   endtask
   initial begin
      n_chk = 0;
      n_err = 0;
      n_ld = 0;
      reset = 1'b0;
      use_prod = 1'b0;
      mif.enter = 1'b0;
      mif.inputdata = 8'h00;
      repeat (3) @(posedge clk);
      #1 chk_cleared("rst");
      reset = 1'b1;
      #1 chk("rel_state", 32'(mif.state), 0);
      @(posedge clk);
      #1 chk("idle_exit_state", 32'(mif.state), 1);
      chk("idle_exit_ready", 32'(mif.inputdata_ready), 1);
      ld0 = n_ld;
      press(8'h12, 1'b1); chk("a_bcnt1", 32'(mif.byte_cnt), 1);
      press(8'h34, 1'b1); chk("a_bcnt2", 32'(mif.byte_cnt), 2);
      press(8'h56, 1'b1); chk("a_bcnt3", 32'(mif.byte_cnt), 3);
      press(8'h78, 1'b1); chk("a_bcnt0", 32'(mif.byte_cnt), 0);
      chk("a_state", 32'(mif.state), 2);
      chk("a_data", mif.dataA, 32'h12345678);
      chk("a_ld_count", 32'(n_ld - ld0), 4);
      press(8'h00, 1'b1); press(8'h00, 1'b1); press(8'h00, 1'b1); press(8'h01, 1'b1);
      chk("show_valid", 32'(mif.result_valid), 1);
      chk("show_result", mif.result, 32'hDEADBEEF);
      chk("show_state", 32'(mif.state), 3);
      chk("show_page0", 32'(mif.disp_page), 0);
      chk("show_ready", 32'(mif.inputdata_ready), 0);
      chk("show_b", mif.dataB, 32'h00000001);
      press(8'h00, 1'b0);
      chk("page1", 32'(mif.disp_page), 1);
      chk("page1_state", 32'(mif.state), 3);
      chk("page1_result", mif.result, 32'hDEADBEEF);
      press(8'h00, 1'b0);
      chk("new_state", 32'(mif.state), 1);
      chk("new_valid", 32'(mif.result_valid), 0);
      chk("new_a", mif.dataA, 0);
      chk("new_b", mif.dataB, 0);
      chk("new_ready", 32'(mif.inputdata_ready), 1);
      chk("new_page", 32'(mif.disp_page), 1);
      use_prod = 1'b1;
      ld0 = n_ld;
      mif.inputdata = 8'h00;
      mif.enter = 1'b1;
      repeat (20) @(posedge clk);
      #1 mif.enter = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("hold_bcnt", 32'(mif.byte_cnt), 1);
      chk("hold_ld_count", 32'(n_ld - ld0), 1);
      press(8'h00, 1'b1); press(8'h00, 1'b1); press(8'h05, 1'b1);
      chk("a5_data", mif.dataA, 32'h00000005);
      chk("a5_state", 32'(mif.state), 2);
      press(8'h00, 1'b1); press(8'h00, 1'b1); press(8'h00, 1'b1);
      // last B byte via short pulses so a second press lands on the final WAIT edge
      ld0 = n_ld;
      mif.inputdata = 8'h03;
      mif.enter = 1'b1;
      @(posedge clk); #1 mif.enter = 1'b0;
      @(posedge clk); #1 mif.enter = 1'b1;
      @(posedge clk);
      #1 chk("b3_ld", 32'(mif.loaddata), 1);
      chk("b3_state", 32'(mif.state), 3);
      chk("b3_bcnt", 32'(mif.byte_cnt), 0);
      chk("b3_ready", 32'(mif.inputdata_ready), 0);
      chk("b3_data", mif.dataB, 32'h00000003);
      mif.enter = 1'b0;
      @(posedge clk);
      #1 chk("wait1_valid", 32'(mif.result_valid), 0);
      chk("wait1_state", 32'(mif.state), 3);
      @(posedge clk);
      #1 chk("lat_valid", 32'(mif.result_valid), 1);
      chk("lat_result", mif.result, 32'h0000000F);
      chk("lat_page", 32'(mif.disp_page), 0);
      repeat (3) @(posedge clk);
      #1 chk("discard_page", 32'(mif.disp_page), 0);
      chk("discard_state", 32'(mif.state), 3);
      chk("discard_ld_count", 32'(n_ld - ld0), 1);
      press(8'h00, 1'b0);
      press(8'h00, 1'b0);
      chk("restart_state", 32'(mif.state), 1);
      repeat (4) press(8'hFF, 1'b1);
      chk("ff_a", mif.dataA, 32'hFFFFFFFF);
      press(8'h00, 1'b1); press(8'h00, 1'b1);
      chk("mid_bcnt", 32'(mif.byte_cnt), 2);
      reset = 1'b0;
      #1 chk_cleared("mid_rst");
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 chk("post_rst_state", 32'(mif.state), 1);
      repeat (4) press(8'hFF, 1'b1);
      press(8'h00, 1'b1); press(8'h00, 1'b1); press(8'h00, 1'b1); press(8'h02, 1'b1);
      chk("trunc_result", mif.result, 32'hFFFFFFFE);
      chk("trunc_valid", 32'(mif.result_valid), 1);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
